// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: owns the program counter, issues instruction-memory
// requests over a ready handshake, and loads the IF/ID pipeline register while
// honouring stall, flush and branch/jump redirect from later stages.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] pc,
   input  logic [31:0] seq_pc,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid
);

   // IDLE: one quiet cycle after reset. FETCH: normal fetching.
   // DROP: an access is in flight whose word must be thrown away once it lands.
   typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc_q;
   logic [31:0] pc_nxt;
   logic [31:0] pending_pc;
   logic [31:0] pending_nxt;
   logic        accept;

   assign pc        = pc_q;
   assign imem_addr = pc_q;

   // A fetched word is only kept when the handshake completes in FETCH and no
   // redirect makes it a wrong-path instruction.
   assign accept = (state == FETCH) && imem_req && imem_ready && !redirect;

   // Next-state, next-PC and request generation.
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc_q;
      pending_nxt = pending_pc;
      imem_req    = 1'b0;
      case (state)
         IDLE: begin
            state_nxt = FETCH;
         end
         FETCH: begin
            imem_req = !stall;
            if (redirect) begin
               // A request that cannot complete this cycle must still be
               // finished on the bus before the target can be fetched.
               if (!stall && !imem_ready) begin
                  pending_nxt = redirect_pc;
                  state_nxt   = DROP;
               end else begin
                  pc_nxt = redirect_pc;
               end
            end else if (!stall && imem_ready) begin
               pc_nxt = seq_pc;
            end
         end
         DROP: begin
            // The outstanding access is held regardless of stall so the
            // address stays stable until memory answers.
            imem_req = 1'b1;
            if (redirect) begin
               pending_nxt = redirect_pc;
            end
            if (imem_ready) begin
               pc_nxt    = redirect ? redirect_pc : pending_pc;
               state_nxt = FETCH;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, PC and pending-target registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         pc_q       <= RESET_PC;
         pending_pc <= 32'h0000_0000;
      end else begin
         state      <= state_nxt;
         pc_q       <= pc_nxt;
         pending_pc <= pending_nxt;
      end
   end

   // IF/ID register: reset > flush > stall hold > accept > bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         if_id_instr <= NOP_INSTR;
         if_id_pc4   <= 32'h0000_0000;
         if_id_valid <= 1'b0;
      end else if (flush) begin
         if_id_instr <= NOP_INSTR;
         if_id_valid <= 1'b0;
      end else if (stall) begin
         if_id_instr <= if_id_instr;
         if_id_pc4   <= if_id_pc4;
         if_id_valid <= if_id_valid;
      end else if (accept) begin
         if_id_instr <= imem_rdata;
         if_id_pc4   <= seq_pc;
         if_id_valid <= 1'b1;
      end else begin
         if_id_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a per-cycle vector table covering
// sequential fetch, wait states, stall, redirect/flush, DROP and reset, plus a
// hand-written start-up latency sequence.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic [31:0] seq_pc;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        flush;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;

   int tests  = 0;
   int failed = 0;

   instruction_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
      .clk         (clk),
      .reset       (reset),
      .pc          (pc),
      .seq_pc      (seq_pc),
      .imem_addr   (imem_addr),
      .imem_req    (imem_req),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .flush       (flush),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .if_id_instr (if_id_instr),
      .if_id_pc4   (if_id_pc4),
      .if_id_valid (if_id_valid)
   );

   always #5 clk = ~clk;

   // External PC adder (+4) and memory whose word encodes its address.
   assign seq_pc     = pc + 32'd4;
   assign imem_rdata = {16'hA5A5, imem_addr[15:0]};

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        stl;
      logic        fl;
      logic        rd;
      logic [31:0] rpc;
      logic [31:0] e_pc;
      logic        e_req;
      logic        e_vld;
      logic [31:0] e_instr;
      logic [31:0] e_pc4;
   } vec_t;

   vec_t vecs[32];

   task automatic check32(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s vec %0d: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rst, input logic rdy, input logic stl, input logic fl,
                               input logic rd, input logic [31:0] rpc, input logic [31:0] e_pc,
                               input logic e_req, input logic e_vld, input logic [31:0] e_instr,
                               input logic [31:0] e_pc4);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.stl = stl; v.fl = fl; v.rd = rd; v.rpc = rpc;
      v.e_pc = e_pc; v.e_req = e_req; v.e_vld = e_vld; v.e_instr = e_instr; v.e_pc4 = e_pc4;
      return v;
   endfunction

   initial begin
      // Each row: inputs applied this cycle, outputs expected before the edge.
      //            rst rdy stl fl rd  rpc            pc             req vld instr          pc4
      vecs[0]  = mk(1, 1, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0);
      vecs[1]  = mk(0, 1, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0);
      vecs[2]  = mk(0, 1, 0, 0, 0, 32'h0,         32'h0,         1, 0, 32'h0,         32'h0);
      vecs[3]  = mk(0, 1, 0, 0, 0, 32'h0,         32'h4,         1, 1, 32'hA5A5_0000, 32'h4);
      vecs[4]  = mk(0, 0, 0, 0, 0, 32'h0,         32'h8,         1, 1, 32'hA5A5_0004, 32'h8);
      vecs[5]  = mk(0, 0, 0, 0, 0, 32'h0,         32'h8,         1, 0, 32'hA5A5_0004, 32'h8);
      vecs[6]  = mk(0, 0, 0, 0, 0, 32'h0,         32'h8,         1, 0, 32'hA5A5_0004, 32'h8);
      vecs[7]  = mk(0, 1, 0, 0, 0, 32'h0,         32'h8,         1, 0, 32'hA5A5_0004, 32'h8);
      vecs[8]  = mk(0, 1, 0, 0, 0, 32'h0,         32'hC,         1, 1, 32'hA5A5_0008, 32'hC);
      vecs[9]  = mk(0, 1, 1, 0, 0, 32'h0,         32'h10,        0, 1, 32'hA5A5_000C, 32'h10);
      vecs[10] = mk(0, 1, 1, 0, 0, 32'h0,         32'h10,        0, 1, 32'hA5A5_000C, 32'h10);
      vecs[11] = mk(0, 1, 0, 0, 0, 32'h0,         32'h10,        1, 1, 32'hA5A5_000C, 32'h10);
      vecs[12] = mk(0, 1, 0, 1, 1, 32'h100,       32'h14,        1, 1, 32'hA5A5_0010, 32'h14);
      vecs[13] = mk(0, 1, 0, 0, 0, 32'h0,         32'h100,       1, 0, 32'h0,         32'h14);
      vecs[14] = mk(0, 1, 0, 0, 0, 32'h0,         32'h104,       1, 1, 32'hA5A5_0100, 32'h104);
      vecs[15] = mk(0, 1, 0, 0, 1, 32'h20,        32'h108,       1, 1, 32'hA5A5_0104, 32'h108);
      vecs[16] = mk(0, 0, 0, 0, 1, 32'h200,       32'h20,        1, 0, 32'hA5A5_0104, 32'h108);
      vecs[17] = mk(0, 0, 1, 0, 1, 32'h300,       32'h20,        1, 0, 32'hA5A5_0104, 32'h108);
      vecs[18] = mk(0, 1, 0, 0, 0, 32'h0,         32'h20,        1, 0, 32'hA5A5_0104, 32'h108);
      vecs[19] = mk(0, 1, 0, 0, 0, 32'h0,         32'h300,       1, 0, 32'hA5A5_0104, 32'h108);
      vecs[20] = mk(0, 1, 0, 0, 0, 32'h0,         32'h304,       1, 1, 32'hA5A5_0300, 32'h304);
      vecs[21] = mk(0, 0, 0, 0, 1, 32'h400,       32'h308,       1, 1, 32'hA5A5_0304, 32'h308);
      vecs[22] = mk(1, 0, 0, 0, 0, 32'h0,         32'h308,       1, 0, 32'hA5A5_0304, 32'h308);
      vecs[23] = mk(0, 1, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0);
      vecs[24] = mk(0, 1, 0, 0, 0, 32'h0,         32'h0,         1, 0, 32'h0,         32'h0);
      vecs[25] = mk(0, 1, 0, 0, 0, 32'h0,         32'h4,         1, 1, 32'hA5A5_0000, 32'h4);
      vecs[26] = mk(0, 1, 1, 0, 1, 32'h500,       32'h8,         0, 1, 32'hA5A5_0004, 32'h8);
      vecs[27] = mk(0, 1, 0, 0, 0, 32'h0,         32'h500,       1, 1, 32'hA5A5_0004, 32'h8);
      vecs[28] = mk(0, 1, 0, 1, 0, 32'h0,         32'h504,       1, 1, 32'hA5A5_0500, 32'h504);
      vecs[29] = mk(0, 1, 0, 0, 1, 32'hFFFF_FFFC, 32'h508,       1, 0, 32'h0,         32'h504);
      vecs[30] = mk(0, 1, 0, 0, 0, 32'h0,         32'hFFFF_FFFC, 1, 0, 32'h0,         32'h504);
      vecs[31] = mk(0, 1, 0, 0, 0, 32'h0,         32'h0,         1, 1, 32'hA5A5_FFFC, 32'h0);

      reset = 1'b1; imem_ready = 1'b1; stall = 1'b0; flush = 1'b0;
      redirect = 1'b0; redirect_pc = 32'h0;
      @(negedge clk);

      for (int i = 0; i < 32; i++) begin
         reset       = vecs[i].rst;
         imem_ready  = vecs[i].rdy;
         stall       = vecs[i].stl;
         flush       = vecs[i].fl;
         redirect    = vecs[i].rd;
         redirect_pc = vecs[i].rpc;
         #1;
         check32("pc",          i, pc,          vecs[i].e_pc);
         check32("imem_addr",   i, imem_addr,   vecs[i].e_pc);
         check32("imem_req",    i, {31'b0, imem_req},    {31'b0, vecs[i].e_req});
         check32("if_id_valid", i, {31'b0, if_id_valid}, {31'b0, vecs[i].e_vld});
         check32("if_id_instr", i, if_id_instr, vecs[i].e_instr);
         check32("if_id_pc4",   i, if_id_pc4,   vecs[i].e_pc4);
         @(negedge clk);
      end

      // Start-up latency: the first request must appear exactly two cycles
      // after reset deasserts; the wait is bounded.
      begin
         int cyc;
         reset = 1'b1; imem_ready = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
         @(negedge clk);
         reset = 1'b0;
         cyc = 1;
         #1;
         while (!imem_req && cyc < 10) begin
            @(negedge clk);
            #1;
            cyc++;
         end
         check32("first_req_cycle", 0, cyc, 2);
         // Back-to-back throughput once fetching: four words in four cycles.
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check32("stream_pc", k, pc, 32'(4 * (k + 1)));
            check32("stream_vld", k, {31'b0, if_id_valid}, 32'd1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
